// File: rtl/logic_op_arb.sv
// ============================================================================
// logic_op_arb : two-port round-robin arbiter feeding a one-stage bitwise
//                logic unit with one result slot per port.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module logic_op_arb #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_reg_logic_sel,
  input  logic          i_en,
  input  logic          i_req_vld_0,
  input  logic          i_req_vld_1,
  input  logic [DW-1:0] i_req_a_0,
  input  logic [DW-1:0] i_req_a_1,
  input  logic [DW-1:0] i_req_b_0,
  input  logic [DW-1:0] i_req_b_1,
  output logic          o_req_rdy_0,
  output logic          o_req_rdy_1,
  output logic          o_rsp_vld_0,
  output logic          o_rsp_vld_1,
  output logic [DW-1:0] o_rsp_data_0,
  output logic [DW-1:0] o_rsp_data_1,
  input  logic          i_rsp_rdy_0,
  input  logic          i_rsp_rdy_1,
  output logic          o_busy,
  output logic [15:0]   o_txn_cnt
);

  logic          s1_vld_q,    s1_vld_d;
  logic [DW-1:0] s1_a_q,      s1_a_d;
  logic [DW-1:0] s1_b_q,      s1_b_d;
  logic [1:0]    s1_sel_q,    s1_sel_d;
  logic          s1_tag_q,    s1_tag_d;
  logic          rsp_vld0_q,  rsp_vld0_d;
  logic          rsp_vld1_q,  rsp_vld1_d;
  logic [DW-1:0] rsp_data0_q, rsp_data0_d;
  logic [DW-1:0] rsp_data1_q, rsp_data1_d;
  logic          ptr_q,       ptr_d;
  logic [15:0]   cnt_q,       cnt_d;

  logic          elig0, elig1;
  logic          cand0, cand1;
  logic          gnt0,  gnt1;
  logic [DW-1:0] s1_result;

  // A port may only issue when its slot is free by the next edge and it has
  // nothing in stage 1, which keeps at most one transaction per port in flight.
  assign elig0 = i_en & ~(s1_vld_q & ~s1_tag_q) & (~rsp_vld0_q | i_rsp_rdy_0);
  assign elig1 = i_en & ~(s1_vld_q &  s1_tag_q) & (~rsp_vld1_q | i_rsp_rdy_1);
  assign cand0 = i_req_vld_0 & elig0;
  assign cand1 = i_req_vld_1 & elig1;
  assign gnt0  = rst_n & cand0 & (~cand1 | ~ptr_q);
  assign gnt1  = rst_n & cand1 & (~cand0 |  ptr_q);

  always_comb begin
    case (s1_sel_q)
      2'd0:    s1_result = s1_a_q & s1_b_q;
      2'd1:    s1_result = s1_a_q | s1_b_q;
      2'd2:    s1_result = s1_a_q ^ s1_b_q;
      default: s1_result = ~s1_a_q;
    endcase
  end

  always_comb begin
    s1_vld_d    = gnt0 | gnt1;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sel_d    = s1_sel_q;
    s1_tag_d    = s1_tag_q;
    if (gnt0) begin
      s1_a_d   = i_req_a_0;
      s1_b_d   = i_req_b_0;
      s1_sel_d = i_reg_logic_sel;
      s1_tag_d = 1'b0;
    end else if (gnt1) begin
      s1_a_d   = i_req_a_1;
      s1_b_d   = i_req_b_1;
      s1_sel_d = i_reg_logic_sel;
      s1_tag_d = 1'b1;
    end

    // Refill from stage 1 takes precedence over the drain on the same edge.
    rsp_vld0_d  = rsp_vld0_q & ~i_rsp_rdy_0;
    rsp_data0_d = rsp_data0_q;
    if (s1_vld_q & ~s1_tag_q) begin
      rsp_vld0_d  = 1'b1;
      rsp_data0_d = s1_result;
    end
    rsp_vld1_d  = rsp_vld1_q & ~i_rsp_rdy_1;
    rsp_data1_d = rsp_data1_q;
    if (s1_vld_q & s1_tag_q) begin
      rsp_vld1_d  = 1'b1;
      rsp_data1_d = s1_result;
    end

    ptr_d = ptr_q;
    if (gnt0) ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;

    cnt_d = cnt_q + {15'd0, (gnt0 | gnt1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= 2'd0;
      s1_tag_q    <= 1'b0;
      rsp_vld0_q  <= 1'b0;
      rsp_vld1_q  <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      ptr_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      s1_tag_q    <= s1_tag_d;
      rsp_vld0_q  <= rsp_vld0_d;
      rsp_vld1_q  <= rsp_vld1_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_req_rdy_0  = gnt0;
  assign o_req_rdy_1  = gnt1;
  assign o_rsp_vld_0  = rsp_vld0_q;
  assign o_rsp_vld_1  = rsp_vld1_q;
  assign o_rsp_data_0 = rsp_data0_q;
  assign o_rsp_data_1 = rsp_data1_q;
  assign o_busy       = s1_vld_q | rsp_vld0_q | rsp_vld1_q;
  assign o_txn_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_arb.sv
// Bench for logic_op_arb: per-cycle vector table plus directed multi-cycle sequences.
`default_nettype none

module tb_logic_op_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        en;
  logic        vld0, vld1;
  logic [31:0] a0, a1, b0, b1;
  logic        rdy0, rdy1;
  logic        rv0, rv1;
  logic [31:0] d0, d1;
  logic        rr0, rr1;
  logic        busy;
  logic [15:0] cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic_op_arb #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_reg_logic_sel(sel), .i_en(en),
    .i_req_vld_0(vld0), .i_req_vld_1(vld1),
    .i_req_a_0(a0), .i_req_a_1(a1), .i_req_b_0(b0), .i_req_b_1(b1),
    .o_req_rdy_0(rdy0), .o_req_rdy_1(rdy1),
    .o_rsp_vld_0(rv0), .o_rsp_vld_1(rv1),
    .o_rsp_data_0(d0), .o_rsp_data_1(d1),
    .i_rsp_rdy_0(rr0), .i_rsp_rdy_1(rr1),
    .o_busy(busy), .o_txn_cnt(cnt)
  );

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr0;
    logic        rr1;
    logic        x_rdy0;
    logic        x_rdy1;
    logic        x_rv0;
    logic        x_rv1;
    logic [31:0] x_d0;
    logic [31:0] x_d1;
    logic        x_busy;
    logic [15:0] x_cnt;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int cyc;
    int k;

    // Single XOR op on port 0, then both ports contending with OR.
    vec[0]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd0};
    vec[1]  = '{1'b1, 2'd2, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd0};
    vec[2]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'd1};
    vec[3]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h0FF00FF0, 32'h0, 1'b1, 16'd1};
    vec[4]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd1};
    vec[5]  = '{1'b1, 2'd1, 1'b1, 32'h000000FF, 32'h00000F00, 1'b1, 32'h12000000, 32'h00340000, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd1};
    vec[6]  = '{1'b1, 2'd1, 1'b1, 32'h000000FF, 32'h00000F00, 1'b1, 32'h12000000, 32'h00340000, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'd2};
    vec[7]  = '{1'b1, 2'd1, 1'b1, 32'h000000FF, 32'h00000F00, 1'b1, 32'h12000000, 32'h00340000, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h12340000, 1'b1, 16'd3};
    vec[8]  = '{1'b1, 2'd1, 1'b1, 32'h000000FF, 32'h00000F00, 1'b1, 32'h12000000, 32'h00340000, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h00000FFF, 32'h0, 1'b1, 16'd4};
    vec[9]  = '{1'b1, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12340000, 1'b1, 16'd5};
    vec[10] = '{1'b1, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h00000FFF, 32'h0, 1'b1, 16'd5};
    vec[11] = '{1'b1, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd5};

    // Reset with requests pending: nothing may be granted.
    rst_n = 1'b0; en = 1'b1; sel = 2'd0;
    vld0 = 1'b1; vld1 = 1'b1; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    rr0 = 1'b1; rr1 = 1'b1;
    repeat (3) next_cycle();
    chk("rst rdy0", rdy0, 0);  chk("rst rdy1", rdy1, 0);
    chk("rst rv0", rv0, 0);    chk("rst rv1", rv1, 0);
    chk("rst d0", d0, 0);      chk("rst d1", d1, 0);
    chk("rst busy", busy, 0);  chk("rst cnt", cnt, 0);
    vld0 = 1'b0; vld1 = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      en = vec[i].en; sel = vec[i].sel;
      vld0 = vec[i].v0; a0 = vec[i].a0; b0 = vec[i].b0;
      vld1 = vec[i].v1; a1 = vec[i].a1; b1 = vec[i].b1;
      rr0 = vec[i].rr0; rr1 = vec[i].rr1;
      #1;
      chk($sformatf("v%0d rdy0", i), rdy0, vec[i].x_rdy0);
      chk($sformatf("v%0d rdy1", i), rdy1, vec[i].x_rdy1);
      chk($sformatf("v%0d rv0", i), rv0, vec[i].x_rv0);
      chk($sformatf("v%0d rv1", i), rv1, vec[i].x_rv1);
      if (vec[i].x_rv0) chk($sformatf("v%0d d0", i), d0, vec[i].x_d0);
      if (vec[i].x_rv1) chk($sformatf("v%0d d1", i), d1, vec[i].x_d1);
      chk($sformatf("v%0d busy", i), busy, vec[i].x_busy);
      chk($sformatf("v%0d cnt", i), cnt, vec[i].x_cnt);
    end

    // Backpressure on port 1 while port 0 keeps streaming.
    next_cycle();
    sel = 2'd2; vld0 = 1'b0; vld1 = 1'b1; a1 = 32'hAAAA5555; b1 = 32'hFFFF0000;
    rr0 = 1'b1; rr1 = 1'b0; #1;
    chk("bp accept1", rdy1, 1);
    next_cycle();
    vld0 = 1'b1; a0 = 32'h0F0F0F0F; b0 = 32'h0; #1;
    chk("bp s1 block rdy1", rdy1, 0);
    chk("bp rdy0", rdy0, 1);
    for (k = 0; k < 5; k++) begin
      next_cycle(); #1;
      chk($sformatf("bp%0d rdy1", k), rdy1, 0);
      chk($sformatf("bp%0d rv1", k), rv1, 1);
      chk($sformatf("bp%0d d1", k), d1, 32'h55555555);
      chk($sformatf("bp%0d rdy0", k), rdy0, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("bp%0d rv0", k), rv0, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) chk($sformatf("bp%0d d0", k), d0, 32'h0F0F0F0F);
    end
    next_cycle();
    rr1 = 1'b1; vld0 = 1'b0; #1;
    chk("bp release rdy1", rdy1, 1);
    chk("bp release rv1", rv1, 1);
    next_cycle();
    vld1 = 1'b0;
    cyc = 0;
    while (busy && cyc < 10) begin
      next_cycle();
      cyc++;
    end
    chk("bp drain busy", busy, 0);

    // Operation select is latched at accept.
    next_cycle();
    sel = 2'd0; vld0 = 1'b1; a0 = 32'hFFFF0000; b0 = 32'h00FFFF00; vld1 = 1'b0; #1;
    chk("sel accept", rdy0, 1);
    next_cycle();
    sel = 2'd3; vld0 = 1'b0; #1;
    chk("sel lat rv0", rv0, 0);
    next_cycle();
    a0 = 32'h0; b0 = 32'h12345678; vld0 = 1'b1; #1;
    chk("sel rv0", rv0, 1);
    chk("sel and d0", d0, 32'h00FF0000);
    chk("sel next rdy0", rdy0, 1);

    // Enable low blocks accepts but lets the in-flight op finish.
    next_cycle();
    en = 1'b0; vld0 = 1'b1; vld1 = 1'b1; #1;
    chk("en0 rdy0", rdy0, 0);
    chk("en0 rdy1", rdy1, 0);
    chk("en0 busy", busy, 1);
    next_cycle(); #1;
    chk("en0 rv0", rv0, 1);
    chk("en0 not d0", d0, 32'hFFFFFFFF);
    chk("en0 rdy1 b", rdy1, 0);
    next_cycle(); #1;
    chk("en0 drained", busy, 0);
    chk("en0 rdy0 b", rdy0, 0);
    en = 1'b1; vld0 = 1'b0; vld1 = 1'b0;

    // Reset one cycle after an accept discards the transaction.
    next_cycle();
    sel = 2'd1; a0 = 32'h1; b0 = 32'h2; vld0 = 1'b1; #1;
    chk("rmid accept", rdy0, 1);
    next_cycle();
    vld0 = 1'b0; rst_n = 1'b0; #1;
    chk("rmid rdy0", rdy0, 0);  chk("rmid rdy1", rdy1, 0);
    chk("rmid rv0", rv0, 0);    chk("rmid rv1", rv1, 0);
    chk("rmid d0", d0, 0);      chk("rmid d1", d1, 0);
    chk("rmid busy", busy, 0);  chk("rmid cnt", cnt, 0);
    for (k = 0; k < 2; k++) begin
      next_cycle(); #1;
      chk($sformatf("rmid hold%0d rv0", k), rv0, 0);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    sel = 2'd2; vld1 = 1'b1; a1 = 32'h3; b1 = 32'h1; #1;
    chk("rmid port1 alone", rdy1, 1);
    next_cycle();
    vld1 = 1'b0; #1;
    chk("rmid rv1 early", rv1, 0);
    next_cycle();
    vld0 = 1'b1; a0 = 32'h0; b0 = 32'h0; #1;
    chk("rmid rv1", rv1, 1);
    chk("rmid d1", d1, 32'h2);
    chk("rmid no stale rv0", rv0, 0);
    chk("rmid cnt1", cnt, 1);
    chk("rmid grant0 ptr", rdy0, 1);

    // Pointer back at port 0 after reset, then drive the counter through wrap.
    next_cycle();
    vld0 = 1'b0; rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1; en = 1'b1; sel = 2'd0; rr0 = 1'b1; rr1 = 1'b1;
    vld0 = 1'b1; vld1 = 1'b1; #1;
    chk("ptr rst rdy0", rdy0, 1);
    chk("ptr rst rdy1", rdy1, 0);
    acc = (rdy0 | rdy1) ? 1 : 0;
    cyc = 0;
    while (acc < 65535 && cyc < 70000) begin
      next_cycle(); #1;
      if (rdy0 | rdy1) acc++;
      cyc++;
    end
    chk("cnt budget", acc, 65535);
    next_cycle();
    vld0 = 1'b0; vld1 = 1'b0; #1;
    chk("cnt ffff", cnt, 16'hFFFF);
    next_cycle();
    vld0 = 1'b1; vld1 = 1'b1; #1;
    chk("cnt one grant", rdy0 ^ rdy1, 1);
    next_cycle();
    vld0 = 1'b0; vld1 = 1'b0; #1;
    chk("cnt wrap", cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
